// File: rtl/mandelbrot_frame_scheduler.sv
// mandelbrot_frame_scheduler
//
// Walks one frame of the pixel grid, issues each pixel's complex coordinate and
// address into a Mandelbrot pipeline, drains the returned iteration counts into
// a framebuffer write port, and pulses `done` when the frame is complete.
//
// Ports
//   clk_in, reset_n            clock, asynchronous active-low reset
//   start                      frame start pulse (IDLE only)
//   re_start/im_start          coordinate of pixel 0
//   re_step/im_step            per-pixel / per-line increments
//   max_iterations             iteration limit, latched on start
//   write_request_out          issue current pixel to the pipeline
//   re_out/im_out              current pixel coordinate
//   pixel_addr_out             current pixel address
//   max_iterations_out         latched iteration limit
//   enable_out/calculating_out frame active
//   buffer_full_in             pipeline input back-pressure
//   data_ready_in              pipeline result valid
//   iterations_in              result iteration count
//   pixel_addr_in              result pixel address
//   output_buffer_overflow_in  pipeline overflow flag
//   data_read_ack_out          one-cycle result acknowledge
//   fb_we/fb_addr/fb_data      framebuffer write slot
//   fb_ready                   framebuffer accepts the write
//   busy                       frame in progress
//   done                       one-cycle frame-complete pulse
//   overflow_err               sticky overflow flag, cleared by start
//   state_dbg                  current FSM state
//
// Handshakes:
//   Issue : a pixel transfers on every clock edge where write_request_out=1;
//           write_request_out is simply "in ISSUE and buffer_full_in=0".
//   Result: data_ready_in is the pipeline's valid; a result is taken when the
//           framebuffer slot is free (empty or being drained this cycle) and
//           no ack was given the cycle before, and is acknowledged by a
//           one-cycle data_read_ack_out pulse in the following cycle.
//   FB    : fb_we is valid, fb_ready is ready; a write transfers on an edge
//           with both high. fb_addr/fb_data hold while fb_we=1 and fb_ready=0.
module mandelbrot_frame_scheduler #(
  parameter int H_RES  = 640,
  parameter int V_RES  = 480,
  parameter int ADDR_W = 22,
  parameter int CNT_W  = 16
) (
  input  logic              clk_in,
  input  logic              reset_n,
  input  logic              start,
  input  logic [31:0]       re_start,
  input  logic [31:0]       im_start,
  input  logic [31:0]       re_step,
  input  logic [31:0]       im_step,
  input  logic [10:0]       max_iterations,
  output logic              write_request_out,
  output logic [31:0]       re_out,
  output logic [31:0]       im_out,
  output logic [ADDR_W-1:0] pixel_addr_out,
  output logic [10:0]       max_iterations_out,
  output logic              enable_out,
  output logic              calculating_out,
  input  logic              buffer_full_in,
  input  logic              data_ready_in,
  input  logic [10:0]       iterations_in,
  input  logic [ADDR_W-1:0] pixel_addr_in,
  input  logic              output_buffer_overflow_in,
  output logic              data_read_ack_out,
  output logic              fb_we,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [10:0]       fb_data,
  input  logic              fb_ready,
  output logic              busy,
  output logic              done,
  output logic              overflow_err,
  output logic [1:0]        state_dbg
);

  localparam int XW = $clog2(H_RES + 1);
  localparam int YW = $clog2(V_RES + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [XW-1:0]     x_q, x_d;
  logic [YW-1:0]     y_q, y_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       re_q, re_d;
  logic [31:0]       im_q, im_d;
  logic [31:0]       re_start_q, re_start_d;
  logic [31:0]       re_step_q, re_step_d;
  logic [31:0]       im_step_q, im_step_d;
  logic [10:0]       max_it_q, max_it_d;
  logic [CNT_W-1:0]  outst_q, outst_d;
  logic              fb_we_q, fb_we_d;
  logic [ADDR_W-1:0] fb_addr_q, fb_addr_d;
  logic [10:0]       fb_data_q, fb_data_d;
  logic              ack_q, ack_d;
  logic              ovf_q, ovf_d;

  logic issue;
  logic capture;
  logic active;

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    addr_d     = addr_q;
    re_d       = re_q;
    im_d       = im_q;
    re_start_d = re_start_q;
    re_step_d  = re_step_q;
    im_step_d  = im_step_q;
    max_it_d   = max_it_q;
    fb_we_d    = fb_we_q;
    fb_addr_d  = fb_addr_q;
    fb_data_d  = fb_data_q;
    ovf_d      = ovf_q | output_buffer_overflow_in;

    active  = (state_q == S_ISSUE) || (state_q == S_DRAIN);
    issue   = (state_q == S_ISSUE) && !buffer_full_in;
    // The !ack_q term stops a data_ready_in that the pipeline has not yet
    // dropped after our ack from being taken a second time.
    capture = active && data_ready_in && (!fb_we_q || fb_ready) && !ack_q;
    ack_d   = capture;

    // Refill wins over drain when both happen in the same cycle.
    if (capture) begin
      fb_we_d   = 1'b1;
      fb_addr_d = pixel_addr_in;
      fb_data_d = iterations_in;
    end else if (fb_ready) begin
      fb_we_d = 1'b0;
    end

    case ({issue, capture})
      2'b10:   outst_d = outst_q + CNT_W'(1);
      2'b01:   outst_d = outst_q - CNT_W'(1);
      default: outst_d = outst_q;
    endcase

    case (state_q)
      S_IDLE: begin
        if (start) begin
          re_start_d = re_start;
          re_step_d  = re_step;
          im_step_d  = im_step;
          max_it_d   = max_iterations;
          x_d        = '0;
          y_d        = '0;
          addr_d     = '0;
          re_d       = re_start;
          im_d       = im_start;
          outst_d    = '0;
          ovf_d      = output_buffer_overflow_in;
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (issue) begin
          addr_d = addr_q + ADDR_W'(1);
          if (x_q != XW'(H_RES - 1)) begin
            x_d  = x_q + XW'(1);
            re_d = re_q + re_step_q;
          end else begin
            x_d  = '0;
            re_d = re_start_q;
            y_d  = y_q + YW'(1);
            im_d = im_q + im_step_q;
            if (y_q == YW'(V_RES - 1)) state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        // Looking at next-state values lets DONE follow the edge on which
        // the last framebuffer write is accepted.
        if (outst_d == '0 && !fb_we_d) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      x_q        <= '0;
      y_q        <= '0;
      addr_q     <= '0;
      re_q       <= '0;
      im_q       <= '0;
      re_start_q <= '0;
      re_step_q  <= '0;
      im_step_q  <= '0;
      max_it_q   <= '0;
      outst_q    <= '0;
      fb_we_q    <= 1'b0;
      fb_addr_q  <= '0;
      fb_data_q  <= '0;
      ack_q      <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      addr_q     <= addr_d;
      re_q       <= re_d;
      im_q       <= im_d;
      re_start_q <= re_start_d;
      re_step_q  <= re_step_d;
      im_step_q  <= im_step_d;
      max_it_q   <= max_it_d;
      outst_q    <= outst_d;
      fb_we_q    <= fb_we_d;
      fb_addr_q  <= fb_addr_d;
      fb_data_q  <= fb_data_d;
      ack_q      <= ack_d;
      ovf_q      <= ovf_d;
    end
  end

  assign write_request_out  = issue;
  assign re_out             = re_q;
  assign im_out             = im_q;
  assign pixel_addr_out     = addr_q;
  assign max_iterations_out = max_it_q;
  assign busy               = (state_q != S_IDLE);
  assign enable_out         = busy;
  assign calculating_out    = busy;
  assign done               = (state_q == S_DONE);
  assign data_read_ack_out  = ack_q;
  assign fb_we              = fb_we_q;
  assign fb_addr            = fb_addr_q;
  assign fb_data            = fb_data_q;
  assign overflow_err       = ovf_q;
  assign state_dbg          = state_q;

endmodule
